f11_wbm: RTL and testbench

F11_WBM -- requirements
Module: f11_wbm

---
 rtl/f11_wbm_pkg.sv | 31 +++
 rtl/f11_wbm_mod.sv | 32 +++
 rtl/f11_wbm.sv | 192 +++++++++++++++++++
 tb/tb_f11_wbm.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/f11_wbm_pkg.sv
// f11_wbm_pkg -- shared definitions for the f11_wbm Wishbone master:
// state encodings, counter defaults and the byte-lane select encoder.
package f11_wbm_pkg;

  // Default widths used as parameter defaults by the master and moderator
  localparam int AW_DEF = 22;
  localparam int TW_DEF = 6;
  localparam int MW_DEF = 6;

  // Counter maxima for the default widths (all-ones saturation values)
  localparam int TMO_MAX_DEF = (1 << TW_DEF) - 1;
  localparam int MOD_MAX_DEF = (1 << MW_DEF) - 1;

  // State enumeration, kept as plain constants for legacy tool flows
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_MWAIT = 3'd1;
  localparam logic [2:0] ST_MSTB  = 3'd2;
  localparam logic [2:0] ST_LOCK  = 3'd3;
  localparam logic [2:0] ST_IAK   = 3'd4;

  // Byte-lane select: reads take both lanes; byte writes pick the lane
  // addressed by bit 0 (odd address -> high lane).
  function automatic logic [1:0] sel_enc(input logic is_wr,
                                         input logic byte_wr,
                                         input logic a0);
    if (!is_wr)
      return 2'b11;
    return {~byte_wr | a0, ~byte_wr | ~a0};
  endfunction

endpackage

// File: rtl/f11_wbm_mod.sv
// f11_wbm_mod -- slow-clock moderator counter. In slow simulation mode it
// counts idle cycles between strobes and then counts them back down on
// vm_clk_ena strobes before a bus cycle may start.
module f11_wbm_mod
  import f11_wbm_pkg::*;
#(
  parameter int MW = MW_DEF
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          slow,
  input  logic          ena,
  input  logic          inc_en,
  input  logic          dec_en,
  output logic [MW-1:0] cnt
);

  localparam logic [MW-1:0] CNT_MAX = '1;

  // Count up while idle without strobe, down while waiting on strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (!slow)
      cnt <= '0;
    else if (inc_en && !ena && cnt != CNT_MAX)
      cnt <= cnt + 1'b1;
    else if (dec_en && ena && cnt != '0)
      cnt <= cnt - 1'b1;
  end

endmodule

// File: rtl/f11_wbm.sv
// f11_wbm -- Wishbone bus master with read/write/RMW-lock transfers,
// interrupt-vector channel, bus timeout and slow-clock moderation.
// Optional feature: define F11_WBM_ERR_EN to add the wbm_err_i bus-error
// input as an extra abort source (ack still wins over err).
module f11_wbm
  import f11_wbm_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int TW = TW_DEF,
  parameter int MW = MW_DEF
) (
  input  logic          vm_clk_p,
  input  logic          vm_rst_n,
  input  logic          vm_clk_ena,
  input  logic          vm_clk_slow,
  input  logic          req_rd,
  input  logic          req_wr,
  input  logic          req_iak,
  input  logic          req_byte,
  input  logic          req_lock,
  input  logic          req_ios,
  input  logic [AW-1:0] req_adr,
  input  logic [15:0]   req_dat,
  output logic          rsp_rdy,
  output logic          rsp_done,
  output logic          rsp_err,
  output logic [15:0]   rsp_dat,
  input  logic          wbm_gnt_i,
  input  logic          wbm_ack_i,
  input  logic [15:0]   wbm_dat_i,
  output logic          wbm_cyc_o,
  output logic          wbm_stb_o,
  output logic          wbm_we_o,
  output logic          wbm_ios_o,
  output logic [1:0]    wbm_sel_o,
  output logic [AW-1:0] wbm_adr_o,
  output logic [15:0]   wbm_dat_o,
  input  logic [15:0]   wbi_dat_i,
  input  logic          wbi_ack_i,
  output logic          wbi_stb_o
`ifdef F11_WBM_ERR_EN
  ,
  input  logic          wbm_err_i
`endif
);

  // Timeout fires on the cycle whose count would reach all-ones
  localparam logic [TW-1:0] TMO_LAST = {{(TW-1){1'b1}}, 1'b0};

  logic [2:0]    state;
  logic [TW-1:0] tmo_cnt;
  logic [MW-1:0] mod_cnt;
  logic          lock_q;
  logic          take_rd;
  logic          take_wr;
  logic          take_iak;
  logic          take_bus;
  logic          tmo_counting;
  logic          tmo_hit;
  logic          bus_err;

  assign rsp_rdy  = (state == ST_IDLE) || (state == ST_LOCK);
  assign take_rd  = rsp_rdy & req_rd;
  assign take_wr  = rsp_rdy & req_wr & ~req_rd;
  assign take_iak = rsp_rdy & req_iak & ~req_rd & ~req_wr;
  assign take_bus = take_rd | take_wr;

  assign tmo_counting = (wbm_stb_o & wbm_gnt_i) | wbi_stb_o;
  assign tmo_hit      = tmo_counting && (tmo_cnt == TMO_LAST);

`ifdef F11_WBM_ERR_EN
  assign bus_err = wbm_err_i;
`else
  assign bus_err = 1'b0;
`endif

  f11_wbm_mod #(
    .MW(MW)
  ) u_mod (
    .clk    (vm_clk_p),
    .rst_n  (vm_rst_n),
    .slow   (vm_clk_slow),
    .ena    (vm_clk_ena),
    .inc_en ((state == ST_IDLE) && !take_bus),
    .dec_en (state == ST_MWAIT),
    .cnt    (mod_cnt)
  );

  // Bus timeout: runs while a strobe is outstanding, clears otherwise
  always_ff @(posedge vm_clk_p or negedge vm_rst_n) begin
    if (!vm_rst_n)
      tmo_cnt <= '0;
    else if (tmo_counting)
      tmo_cnt <= tmo_cnt + 1'b1;
    else
      tmo_cnt <= '0;
  end

  // Transfer sequencer: accepts requests, drives the bus, reports result
  always_ff @(posedge vm_clk_p or negedge vm_rst_n) begin
    if (!vm_rst_n) begin
      state     <= ST_IDLE;
      lock_q    <= 1'b0;
      wbm_cyc_o <= 1'b0;
      wbm_stb_o <= 1'b0;
      wbm_we_o  <= 1'b0;
      wbm_ios_o <= 1'b0;
      wbm_sel_o <= 2'b00;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
      wbi_stb_o <= 1'b0;
      rsp_done  <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_dat   <= '0;
    end else begin
      rsp_done <= 1'b0;
      rsp_err  <= 1'b0;
      case (state)
        ST_IDLE, ST_LOCK: begin
          if (take_bus) begin
            wbm_adr_o <= req_adr;
            wbm_ios_o <= req_ios;
            wbm_dat_o <= req_dat;
            wbm_we_o  <= take_wr;
            wbm_sel_o <= sel_enc(take_wr, req_byte, req_adr[0]);
            lock_q    <= req_lock;
            if (state == ST_LOCK || !vm_clk_slow || mod_cnt == '0) begin
              state     <= ST_MSTB;
              wbm_cyc_o <= 1'b1;
              wbm_stb_o <= 1'b1;
            end else begin
              state <= ST_MWAIT;
            end
          end else if (take_iak) begin
            state     <= ST_IAK;
            lock_q    <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbi_stb_o <= 1'b1;
          end
        end
        ST_MWAIT: begin
          if (mod_cnt == '0) begin
            state     <= ST_MSTB;
            wbm_cyc_o <= 1'b1;
            wbm_stb_o <= 1'b1;
          end
        end
        ST_MSTB: begin
          if (wbm_ack_i) begin
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            rsp_done  <= 1'b1;
            if (!wbm_we_o)
              rsp_dat <= wbm_dat_i;
            if (lock_q) begin
              state <= ST_LOCK;
            end else begin
              state     <= ST_IDLE;
              wbm_cyc_o <= 1'b0;
            end
          end else if (tmo_hit || bus_err) begin
            state     <= ST_IDLE;
            lock_q    <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_cyc_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            rsp_err   <= 1'b1;
          end
        end
        ST_IAK: begin
          if (wbi_ack_i) begin
            state     <= ST_IDLE;
            wbi_stb_o <= 1'b0;
            rsp_dat   <= wbi_dat_i;
            rsp_done  <= 1'b1;
          end else if (tmo_hit) begin
            state     <= ST_IDLE;
            wbi_stb_o <= 1'b0;
            rsp_err   <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          wbm_cyc_o <= 1'b0;
          wbm_stb_o <= 1'b0;
          wbi_stb_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_f11_wbm.sv
// tb_f11_wbm -- directed self-checking bench for f11_wbm. Build with
// F11_WBM_ERR_EN defined to also exercise the bus-error input.
module tb_f11_wbm;

  localparam int AW = 22;

  logic          vm_clk_p;
  logic          vm_rst_n;
  logic          vm_clk_ena;
  logic          vm_clk_slow;
  logic          req_rd;
  logic          req_wr;
  logic          req_iak;
  logic          req_byte;
  logic          req_lock;
  logic          req_ios;
  logic [AW-1:0] req_adr;
  logic [15:0]   req_dat;
  logic          rsp_rdy;
  logic          rsp_done;
  logic          rsp_err;
  logic [15:0]   rsp_dat;
  logic          wbm_gnt_i;
  logic          wbm_ack_i;
  logic [15:0]   wbm_dat_i;
  logic          wbm_cyc_o;
  logic          wbm_stb_o;
  logic          wbm_we_o;
  logic          wbm_ios_o;
  logic [1:0]    wbm_sel_o;
  logic [AW-1:0] wbm_adr_o;
  logic [15:0]   wbm_dat_o;
  logic [15:0]   wbi_dat_i;
  logic          wbi_ack_i;
  logic          wbi_stb_o;
`ifdef F11_WBM_ERR_EN
  logic          wbm_err_i;
`endif

  int check_cnt = 0;
  int pass_cnt  = 0;
  int fail_cnt  = 0;
  int early_err;

  f11_wbm #(
    .AW(AW),
    .TW(6),
    .MW(6)
  ) dut (
    .vm_clk_p    (vm_clk_p),
    .vm_rst_n    (vm_rst_n),
    .vm_clk_ena  (vm_clk_ena),
    .vm_clk_slow (vm_clk_slow),
    .req_rd      (req_rd),
    .req_wr      (req_wr),
    .req_iak     (req_iak),
    .req_byte    (req_byte),
    .req_lock    (req_lock),
    .req_ios     (req_ios),
    .req_adr     (req_adr),
    .req_dat     (req_dat),
    .rsp_rdy     (rsp_rdy),
    .rsp_done    (rsp_done),
    .rsp_err     (rsp_err),
    .rsp_dat     (rsp_dat),
    .wbm_gnt_i   (wbm_gnt_i),
    .wbm_ack_i   (wbm_ack_i),
    .wbm_dat_i   (wbm_dat_i),
    .wbm_cyc_o   (wbm_cyc_o),
    .wbm_stb_o   (wbm_stb_o),
    .wbm_we_o    (wbm_we_o),
    .wbm_ios_o   (wbm_ios_o),
    .wbm_sel_o   (wbm_sel_o),
    .wbm_adr_o   (wbm_adr_o),
    .wbm_dat_o   (wbm_dat_o),
    .wbi_dat_i   (wbi_dat_i),
    .wbi_ack_i   (wbi_ack_i),
    .wbi_stb_o   (wbi_stb_o)
`ifdef F11_WBM_ERR_EN
    ,
    .wbm_err_i   (wbm_err_i)
`endif
  );

  // Free-running 100 MHz clock
  initial begin
    vm_clk_p = 1'b0;
    forever #5 vm_clk_p = ~vm_clk_p;
  end

  // Advance to just after the next rising edge
  task automatic tick();
    @(posedge vm_clk_p);
    #1;
  endtask

  // Compare one observed value against its hand-computed expectation
  task automatic check_output(input string tag, input logic [31:0] obs,
                              input logic [31:0] exp);
    check_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("[TB] FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Present a one-cycle request pulse and return after the accepting edge
  task automatic apply_stimulus(input logic rd, input logic wr, input logic iak,
                                input logic byte_wr, input logic lock,
                                input logic [AW-1:0] adr, input logic [15:0] dat);
    req_rd   = rd;
    req_wr   = wr;
    req_iak  = iak;
    req_byte = byte_wr;
    req_lock = lock;
    req_adr  = adr;
    req_dat  = dat;
    tick();
    req_rd   = 1'b0;
    req_wr   = 1'b0;
    req_iak  = 1'b0;
    req_byte = 1'b0;
    req_lock = 1'b0;
  endtask

  // Drive the bus ack for one cycle with the given read data
  task automatic bus_ack(input logic [15:0] dat);
    wbm_ack_i = 1'b1;
    wbm_dat_i = dat;
    tick();
    wbm_ack_i = 1'b0;
    wbm_dat_i = 16'h0000;
  endtask

  // Directed sequence of transfers with expected values worked by hand
  initial begin
    vm_rst_n    = 1'b0;
    vm_clk_ena  = 1'b0;
    vm_clk_slow = 1'b0;
    req_rd      = 1'b0;
    req_wr      = 1'b0;
    req_iak     = 1'b0;
    req_byte    = 1'b0;
    req_lock    = 1'b0;
    req_ios     = 1'b0;
    req_adr     = '0;
    req_dat     = 16'h0000;
    wbm_gnt_i   = 1'b1;
    wbm_ack_i   = 1'b0;
    wbm_dat_i   = 16'h0000;
    wbi_dat_i   = 16'h0000;
    wbi_ack_i   = 1'b0;
`ifdef F11_WBM_ERR_EN
    wbm_err_i   = 1'b0;
`endif

    // Reset state
    #12;
    check_output("rst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    check_output("rst_stb", {31'd0, wbm_stb_o}, 32'd0);
    check_output("rst_sel", {30'd0, wbm_sel_o}, 32'd0);
    check_output("rst_rdy", {31'd0, rsp_rdy}, 32'd1);
    check_output("rst_dat", {16'd0, rsp_dat}, 32'd0);
    vm_rst_n = 1'b1;
    tick();
    tick();

    // Word read; a write pulse while busy must be ignored
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 22'h3FF000, 16'h0000);
    check_output("rd_stb", {31'd0, wbm_stb_o}, 32'd1);
    check_output("rd_cyc", {31'd0, wbm_cyc_o}, 32'd1);
    check_output("rd_we", {31'd0, wbm_we_o}, 32'd0);
    check_output("rd_sel", {30'd0, wbm_sel_o}, 32'd3);
    check_output("rd_adr", {10'd0, wbm_adr_o}, 32'h003FF000);
    check_output("rd_busy_rdy", {31'd0, rsp_rdy}, 32'd0);
    req_wr = 1'b1;
    tick();
    req_wr = 1'b0;
    check_output("rd_ignore_we", {31'd0, wbm_we_o}, 32'd0);
    bus_ack(16'h1234);
    check_output("rd_done", {31'd0, rsp_done}, 32'd1);
    check_output("rd_data", {16'd0, rsp_dat}, 32'h1234);
    check_output("rd_cyc_low", {31'd0, wbm_cyc_o}, 32'd0);
    check_output("rd_stb_low", {31'd0, wbm_stb_o}, 32'd0);
    tick();
    check_output("rd_done_pulse", {31'd0, rsp_done}, 32'd0);
    check_output("rd_no_restart", {31'd0, wbm_stb_o}, 32'd0);
    check_output("rd_data_hold", {16'd0, rsp_dat}, 32'h1234);

    // Byte write to odd then even address
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 22'h000101, 16'hAB00);
    check_output("bw_odd_sel", {30'd0, wbm_sel_o}, 32'h2);
    check_output("bw_odd_we", {31'd0, wbm_we_o}, 32'd1);
    check_output("bw_odd_dat", {16'd0, wbm_dat_o}, 32'hAB00);
    bus_ack(16'h5A5A);
    check_output("bw_odd_done", {31'd0, rsp_done}, 32'd1);
    check_output("bw_odd_we_drop", {31'd0, wbm_we_o}, 32'd0);
    check_output("bw_keep_rdat", {16'd0, rsp_dat}, 32'h1234);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 22'h000100, 16'h00CD);
    check_output("bw_even_sel", {30'd0, wbm_sel_o}, 32'h1);
    bus_ack(16'h0000);

    // Simultaneous rd and wr: read wins
    apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 22'h000042, 16'hFFFF);
    check_output("prio_we", {31'd0, wbm_we_o}, 32'd0);
    check_output("prio_sel", {30'd0, wbm_sel_o}, 32'd3);
    bus_ack(16'h0F0F);
    check_output("prio_data", {16'd0, rsp_dat}, 32'h0F0F);

    // Read-modify-write with lock
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 22'h000200, 16'h0000);
    bus_ack(16'h5555);
    check_output("rmw_done", {31'd0, rsp_done}, 32'd1);
    check_output("rmw_cyc_held", {31'd0, wbm_cyc_o}, 32'd1);
    check_output("rmw_stb_low", {31'd0, wbm_stb_o}, 32'd0);
    check_output("rmw_rdy", {31'd0, rsp_rdy}, 32'd1);
    apply_stimulus(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 22'h000200, 16'h5556);
    check_output("rmw_wr_stb", {31'd0, wbm_stb_o}, 32'd1);
    check_output("rmw_wr_we", {31'd0, wbm_we_o}, 32'd1);
    bus_ack(16'h0000);
    check_output("rmw_cyc_drop", {31'd0, wbm_cyc_o}, 32'd0);

    // Interrupt-vector fetch
    apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 22'h000000, 16'h0000);
    check_output("iak_stb", {31'd0, wbi_stb_o}, 32'd1);
    check_output("iak_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    wbi_ack_i = 1'b1;
    wbi_dat_i = 16'hBEEF;
    tick();
    wbi_ack_i = 1'b0;
    check_output("iak_done", {31'd0, rsp_done}, 32'd1);
    check_output("iak_data", {16'd0, rsp_dat}, 32'hBEEF);
    check_output("iak_stb_low", {31'd0, wbi_stb_o}, 32'd0);

    // Timeout: rsp_err exactly 63 cycles after stb rises
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 22'h000300, 16'h0000);
    check_output("tmo_stb", {31'd0, wbm_stb_o}, 32'd1);
    early_err = 0;
    for (int i = 1; i <= 62; i++) begin
      tick();
      if (rsp_err || !wbm_stb_o)
        early_err++;
    end
    check_output("tmo_early", early_err, 32'd0);
    tick();
    check_output("tmo_err", {31'd0, rsp_err}, 32'd1);
    check_output("tmo_stb_drop", {31'd0, wbm_stb_o}, 32'd0);
    check_output("tmo_cyc_drop", {31'd0, wbm_cyc_o}, 32'd0);
    check_output("tmo_rdy", {31'd0, rsp_rdy}, 32'd1);
    check_output("tmo_no_done", {31'd0, rsp_done}, 32'd0);
    tick();
    check_output("tmo_err_pulse", {31'd0, rsp_err}, 32'd0);
    check_output("tmo_lock_rel", {31'd0, wbm_cyc_o}, 32'd0);

    // Slow mode: 10 idle cycles, then 10 strobes before stb
    vm_clk_slow = 1'b1;
    repeat (10) tick();
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 22'h000400, 16'h0000);
    check_output("slow_wait", {31'd0, wbm_stb_o}, 32'd0);
    for (int k = 1; k <= 10; k++) begin
      vm_clk_ena = 1'b1;
      tick();
      vm_clk_ena = 1'b0;
      tick();
      check_output($sformatf("slow_stb_%0d", k), {31'd0, wbm_stb_o},
                   (k == 10) ? 32'd1 : 32'd0);
    end
    bus_ack(16'h2468);
    check_output("slow_data", {16'd0, rsp_dat}, 32'h2468);
    vm_clk_slow = 1'b0;
    tick();

    // Reset during an active strobe
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 22'h000155, 16'h0000);
    check_output("mrst_pre_stb", {31'd0, wbm_stb_o}, 32'd1);
    #2;
    vm_rst_n = 1'b0;
    #1;
    check_output("mrst_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    check_output("mrst_stb", {31'd0, wbm_stb_o}, 32'd0);
    check_output("mrst_sel", {30'd0, wbm_sel_o}, 32'd0);
    check_output("mrst_adr", {10'd0, wbm_adr_o}, 32'd0);
    check_output("mrst_done", {31'd0, rsp_done}, 32'd0);
    check_output("mrst_err", {31'd0, rsp_err}, 32'd0);
    check_output("mrst_rdy", {31'd0, rsp_rdy}, 32'd1);
    #2;
    vm_rst_n = 1'b1;
    tick();
    check_output("mrst_post_err", {31'd0, rsp_err}, 32'd0);
    check_output("mrst_post_cyc", {31'd0, wbm_cyc_o}, 32'd0);

`ifdef F11_WBM_ERR_EN
    // Bus error aborts; ack beats err when both arrive together
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 22'h000500, 16'h0000);
    wbm_err_i = 1'b1;
    tick();
    wbm_err_i = 1'b0;
    check_output("berr_err", {31'd0, rsp_err}, 32'd1);
    check_output("berr_cyc", {31'd0, wbm_cyc_o}, 32'd0);
    check_output("berr_done", {31'd0, rsp_done}, 32'd0);
    tick();
    apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 22'h000502, 16'h0000);
    wbm_err_i = 1'b1;
    bus_ack(16'h7777);
    wbm_err_i = 1'b0;
    check_output("berr_ack_done", {31'd0, rsp_done}, 32'd1);
    check_output("berr_ack_err", {31'd0, rsp_err}, 32'd0);
    check_output("berr_ack_data", {16'd0, rsp_dat}, 32'h7777);
`endif

    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
